// File: rtl/mcu_reg_timer_pkg.sv
// Shared definitions for the MCU register bank / PWM timer slice.
package mcu_reg_timer_pkg;

    // Register map (4-bit bus address space; 0x8-0xF decode to nothing)
    localparam logic [3:0] REG_CTRL     = 4'h0;
    localparam logic [3:0] REG_CMD      = 4'h1;
    localparam logic [3:0] REG_PERIOD_L = 4'h2;
    localparam logic [3:0] REG_PERIOD_H = 4'h3;
    localparam logic [3:0] REG_DUTY_L   = 4'h4;
    localparam logic [3:0] REG_DUTY_H   = 4'h5;
    localparam logic [3:0] REG_PRESCALE = 4'h6;
    localparam logic [3:0] REG_GPO      = 4'h7;

    // CTRL bit positions
    localparam int CTRL_AUTO_RELOAD = 0;
    localparam int CTRL_PWM_EN      = 1;
    localparam int CTRL_IRQ_EN      = 2;

    // CMD bit positions (write-only strobes)
    localparam int CMD_START   = 0;
    localparam int CMD_STOP    = 1;
    localparam int CMD_IRQ_CLR = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/mcu_pwm_timer.sv
// Prescaled interval/PWM timer: FSM, prescaler, counter, active period/duty
// registers and the PWM compare. irq_set is a one-cycle pulse on the final
// tick of a period; the sticky flag lives in the register bank.
module mcu_pwm_timer
    import mcu_reg_timer_pkg::*;
#(
    parameter int TW = 16,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [TW-1:0] period_shadow,
    input  logic [TW-1:0] duty_shadow,
    input  logic [PW-1:0] prescale,
    input  logic          auto_reload,
    input  logic          pwm_en,
    input  logic          start,
    input  logic          stop,
    output logic          tmr_busy,
    output logic          pwm_out,
    output logic          irq_set
);

    tmr_state_e    state;
    logic [TW-1:0] cnt;
    logic [PW-1:0] presc_cnt;
    logic [TW-1:0] period_active;
    logic [TW-1:0] duty_active;

    logic tick;
    logic last_tick;
    logic do_start;

    // >= rather than == so a PRESCALE lowered mid-run below presc_cnt
    // still ticks on the next clock instead of wrapping through 2^PW.
    assign tick      = (state == RUN) && (presc_cnt >= prescale);
    assign last_tick = tick && (cnt == period_active - TW'(1));
    // stop beats start; a zero period can never start the timer
    assign do_start  = start && !stop && (period_shadow != '0);
    assign irq_set   = last_tick;

    // Timer FSM with counter, prescaler and registered busy/pwm outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            presc_cnt     <= '0;
            period_active <= '0;
            duty_active   <= '0;
            tmr_busy      <= 1'b0;
            pwm_out       <= 1'b0;
        end else begin
            pwm_out <= pwm_en && (state == RUN) && (cnt < duty_active);
            case (state)
                IDLE, DONE: begin
                    if (stop) begin
                        state    <= IDLE;
                        tmr_busy <= 1'b0;
                    end else if (do_start) begin
                        state         <= RUN;
                        tmr_busy      <= 1'b1;
                        cnt           <= '0;
                        presc_cnt     <= '0;
                        period_active <= period_shadow;
                        duty_active   <= duty_shadow;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // counters deliberately hold their values
                        state    <= IDLE;
                        tmr_busy <= 1'b0;
                    end else if (do_start) begin
                        cnt           <= '0;
                        presc_cnt     <= '0;
                        period_active <= period_shadow;
                        duty_active   <= duty_shadow;
                    end else if (tick) begin
                        presc_cnt <= '0;
                        if (last_tick) begin
                            if (auto_reload) begin
                                cnt           <= '0;
                                period_active <= period_shadow;
                                duty_active   <= duty_shadow;
                            end else begin
                                state    <= DONE;
                                tmr_busy <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + TW'(1);
                        end
                    end else begin
                        presc_cnt <= presc_cnt + PW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    tmr_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mcu_reg_timer.sv
// Register bank fed by the bus capture stage: address decode, CTRL,
// staged/shadow period and duty, PRESCALE, GPO and the sticky irq flag.
// The timer itself lives in mcu_pwm_timer.
module mcu_reg_timer
    import mcu_reg_timer_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_pulse,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] gpo,
    output logic              pwm_out,
    output logic              tmr_busy,
    output logic              tmr_irq
);

    localparam int TW = 2 * DATA_W;

    logic [2:0]        ctrl_q;
    logic [DATA_W-1:0] period_l_stage;
    logic [DATA_W-1:0] duty_l_stage;
    logic [TW-1:0]     period_shadow;
    logic [TW-1:0]     duty_shadow;
    logic [DATA_W-1:0] prescale_q;
    logic              irq_flag;

    logic wr_ctrl, wr_cmd, wr_per_l, wr_per_h, wr_duty_l, wr_duty_h, wr_presc, wr_gpo;
    logic cmd_start, cmd_stop, cmd_irq_clr;
    logic irq_set;
    logic irq_flag_nxt;
    logic irq_en_nxt;

    // Full-width address compare so 0x8-0xF alias nothing
    assign wr_ctrl   = wr_pulse && (wr_addr == ADDR_W'(REG_CTRL));
    assign wr_cmd    = wr_pulse && (wr_addr == ADDR_W'(REG_CMD));
    assign wr_per_l  = wr_pulse && (wr_addr == ADDR_W'(REG_PERIOD_L));
    assign wr_per_h  = wr_pulse && (wr_addr == ADDR_W'(REG_PERIOD_H));
    assign wr_duty_l = wr_pulse && (wr_addr == ADDR_W'(REG_DUTY_L));
    assign wr_duty_h = wr_pulse && (wr_addr == ADDR_W'(REG_DUTY_H));
    assign wr_presc  = wr_pulse && (wr_addr == ADDR_W'(REG_PRESCALE));
    assign wr_gpo    = wr_pulse && (wr_addr == ADDR_W'(REG_GPO));

    // CMD is never stored; its bits are strobes for this cycle only
    assign cmd_start   = wr_cmd && wr_data[CMD_START];
    assign cmd_stop    = wr_cmd && wr_data[CMD_STOP];
    assign cmd_irq_clr = wr_cmd && wr_data[CMD_IRQ_CLR];

    // Set beats clear when both land in the same cycle
    assign irq_flag_nxt = irq_set ? 1'b1 : (cmd_irq_clr ? 1'b0 : irq_flag);
    assign irq_en_nxt   = wr_ctrl ? wr_data[CTRL_IRQ_EN] : ctrl_q[CTRL_IRQ_EN];

    // Control, staging/shadow and GPO registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q         <= '0;
            period_l_stage <= '0;
            duty_l_stage   <= '0;
            period_shadow  <= '0;
            duty_shadow    <= '0;
            prescale_q     <= '0;
            gpo            <= '0;
        end else begin
            if (wr_ctrl)   ctrl_q         <= wr_data[2:0];
            if (wr_per_l)  period_l_stage <= wr_data;
            if (wr_per_h)  period_shadow  <= {wr_data, period_l_stage};
            if (wr_duty_l) duty_l_stage   <= wr_data;
            if (wr_duty_h) duty_shadow    <= {wr_data, duty_l_stage};
            if (wr_presc)  prescale_q     <= wr_data;
            if (wr_gpo)    gpo            <= wr_data;
        end
    end

    // Sticky irq flag and its registered, enable-gated output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_flag <= 1'b0;
            tmr_irq  <= 1'b0;
        end else begin
            irq_flag <= irq_flag_nxt;
            tmr_irq  <= irq_flag_nxt && irq_en_nxt;
        end
    end

    mcu_pwm_timer #(
        .TW (TW),
        .PW (DATA_W)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .period_shadow (period_shadow),
        .duty_shadow   (duty_shadow),
        .prescale      (prescale_q),
        .auto_reload   (ctrl_q[CTRL_AUTO_RELOAD]),
        .pwm_en        (ctrl_q[CTRL_PWM_EN]),
        .start         (cmd_start),
        .stop          (cmd_stop),
        .tmr_busy      (tmr_busy),
        .pwm_out       (pwm_out),
        .irq_set       (irq_set)
    );

endmodule

// File: tb/tb_mcu_reg_timer.sv
// Directed bench for mcu_reg_timer. Inputs change on the falling edge,
// outputs are sampled on the falling edge; expected values are hand-derived.
module tb_mcu_reg_timer;

    logic       clk;
    logic       rst_n;
    logic       wr_pulse;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] gpo;
    logic       pwm_out;
    logic       tmr_busy;
    logic       tmr_irq;

    int errors = 0;
    int checks = 0;

    mcu_reg_timer #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .gpo      (gpo),
        .pwm_out  (pwm_out),
        .tmr_busy (tmr_busy),
        .tmr_irq  (tmr_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the next falling edge, after the
    // rising edge that captured the write.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        wr_pulse = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk);
        wr_pulse = 1'b0;
        wr_addr  = 4'h0;
        wr_data  = 8'h00;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gpo, pwm_out, tmr_busy, tmr_irq} !== 11'd0) begin
            errors++;
            $display("FAIL reset_init: got gpo=%h pwm=%b busy=%b irq=%b want all 0", gpo, pwm_out, tmr_busy, tmr_irq);
        end
        wr(4'h7, 8'h3C);
        wr(4'h6, 8'h00); wr(4'h2, 8'h04); wr(4'h3, 8'h00);
        wr(4'h4, 8'hFF); wr(4'h5, 8'hFF); wr(4'h0, 8'h07);
        wr(4'h1, 8'h01);
        cyc(3);
        checks++;
        if (tmr_busy !== 1'b1 || pwm_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_prerun: got busy=%b pwm=%b want 1 1", tmr_busy, pwm_out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({gpo, pwm_out, tmr_busy, tmr_irq} !== 11'd0) begin
            errors++;
            $display("FAIL reset_midrun: got gpo=%h pwm=%b busy=%b irq=%b want all 0", gpo, pwm_out, tmr_busy, tmr_irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // period shadow must be cleared, so a start is ignored
        wr(4'h1, 8'h01);
        cyc(1);
        checks++;
        if (tmr_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_shadow_clear: got busy=%b want 0", tmr_busy);
        end
        wr(4'h7, 8'hA5);
        checks++;
        if (gpo !== 8'hA5) begin
            errors++;
            $display("FAIL gpo_write: got %h want a5", gpo);
        end
    endtask

    task automatic test_basic_pwm();
        do_reset();
        wr(4'h6, 8'h00); wr(4'h2, 8'h04); wr(4'h3, 8'h00);
        wr(4'h4, 8'h01); wr(4'h5, 8'h00); wr(4'h0, 8'h03);
        wr(4'h1, 8'h01);
        checks++;
        if (tmr_busy !== 1'b1) begin
            errors++;
            $display("FAIL pwm_busy: got %b want 1", tmr_busy);
        end
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            checks++;
            if (pwm_out !== (k % 4 == 1) || tmr_irq !== 1'b0) begin
                errors++;
                $display("FAIL pwm_pattern k=%0d: got pwm=%b irq=%b want pwm=%b irq=0", k, pwm_out, tmr_irq, (k % 4 == 1));
            end
        end
    endtask

    task automatic test_one_shot();
        do_reset();
        wr(4'h6, 8'h02); wr(4'h2, 8'h03); wr(4'h3, 8'h00);
        wr(4'h0, 8'h04);
        wr(4'h1, 8'h01);
        checks++;
        if (tmr_busy !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_busy_rise: got %b want 1", tmr_busy);
        end
        for (int k = 1; k <= 9; k++) begin
            cyc(1);
            checks++;
            if (tmr_busy !== (k < 9) || tmr_irq !== (k == 9)) begin
                errors++;
                $display("FAIL oneshot k=%0d: got busy=%b irq=%b want busy=%b irq=%b", k, tmr_busy, tmr_irq, (k < 9), (k == 9));
            end
        end
        cyc(2);
        checks++;
        if (tmr_busy !== 1'b0 || tmr_irq !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_done_hold: got busy=%b irq=%b want 0 1", tmr_busy, tmr_irq);
        end
        wr(4'h1, 8'h04);
        checks++;
        if (tmr_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clr: got %b want 0", tmr_irq);
        end
    endtask

    task automatic test_shadow_update();
        do_reset();
        wr(4'h6, 8'h00); wr(4'h2, 8'h04); wr(4'h3, 8'h00);
        wr(4'h4, 8'h01); wr(4'h5, 8'h00); wr(4'h0, 8'h03);
        wr(4'h1, 8'h01);
        wr(4'h2, 8'h08);
        checks++;
        if (pwm_out !== 1'b1) begin
            errors++;
            $display("FAIL shadow_first_pulse: got %b want 1", pwm_out);
        end
        wr(4'h3, 8'h00);
        for (int k = 3; k <= 13; k++) begin
            cyc(1);
            checks++;
            if (pwm_out !== (k == 5 || k == 13)) begin
                errors++;
                $display("FAIL shadow_period k=%0d: got %b want %b", k, pwm_out, (k == 5 || k == 13));
            end
        end
    endtask

    task automatic test_boundary();
        do_reset();
        wr(4'h1, 8'h01);
        cyc(2);
        checks++;
        if (tmr_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_period_start: got busy=%b want 0", tmr_busy);
        end
        wr(4'h6, 8'h00); wr(4'h2, 8'h04); wr(4'h3, 8'h00);
        wr(4'h4, 8'hFF); wr(4'h5, 8'hFF); wr(4'h0, 8'h03);
        wr(4'h1, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            cyc(1);
            checks++;
            if (pwm_out !== 1'b1) begin
                errors++;
                $display("FAIL duty_full k=%0d: got %b want 1", k, pwm_out);
            end
        end
        wr(4'h1, 8'h03);
        checks++;
        if (tmr_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_run: got busy=%b want 0", tmr_busy);
        end
        cyc(1);
        checks++;
        if (pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL pwm_after_stop: got %b want 0", pwm_out);
        end
        wr(4'h1, 8'h03);
        cyc(1);
        checks++;
        if (tmr_busy !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_idle: got busy=%b want 0", tmr_busy);
        end
        wr(4'h4, 8'h00); wr(4'h5, 8'h00);
        wr(4'h1, 8'h01);
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            checks++;
            if (pwm_out !== 1'b0 || tmr_busy !== 1'b1) begin
                errors++;
                $display("FAIL duty_zero k=%0d: got pwm=%b busy=%b want 0 1", k, pwm_out, tmr_busy);
            end
        end
    endtask

    task automatic test_irq_race();
        do_reset();
        wr(4'h6, 8'h02); wr(4'h2, 8'h03); wr(4'h3, 8'h00);
        wr(4'h0, 8'h04);
        wr(4'h1, 8'h01);
        cyc(8);
        wr(4'h1, 8'h04);
        checks++;
        if (tmr_irq !== 1'b1 || tmr_busy !== 1'b0) begin
            errors++;
            $display("FAIL irq_set_wins: got irq=%b busy=%b want 1 0", tmr_irq, tmr_busy);
        end
        cyc(2);
        checks++;
        if (tmr_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_sticky: got %b want 1", tmr_irq);
        end
        wr(4'h1, 8'h04);
        checks++;
        if (tmr_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clr_after_race: got %b want 0", tmr_irq);
        end
    endtask

    task automatic test_ignored_addr();
        do_reset();
        wr(4'h7, 8'h5A);
        wr(4'h2, 8'h04); wr(4'h3, 8'h00);
        wr(4'hC, 8'hFF);
        wr(4'hF, 8'hFF);
        checks++;
        if (gpo !== 8'h5A) begin
            errors++;
            $display("FAIL ignored_gpo: got %h want 5a", gpo);
        end
        wr(4'h9, 8'h01);
        cyc(1);
        checks++;
        if (tmr_busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_cmd: got busy=%b want 0", tmr_busy);
        end
        wr(4'h1, 8'h01);
        checks++;
        if (tmr_busy !== 1'b1) begin
            errors++;
            $display("FAIL valid_start: got busy=%b want 1", tmr_busy);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            wr(4'h7, 8'(i * 17));
            checks++;
            if (gpo !== 8'(i * 17)) begin
                errors++;
                $display("FAIL b2b_gpo i=%0d: got %h want %h", i, gpo, 8'(i * 17));
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_pulse = 1'b0;
        wr_addr  = 4'h0;
        wr_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic_pwm();
        test_one_shot();
        test_shadow_update();
        test_boundary();
        test_irq_race();
        test_ignored_addr();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
